key_schedule_gen: RTL
=====================

KEY_SCHEDULE_GEN -- requirements
Module: key_schedule_gen

Interface
REQ-001 SHALL have parameter KEY_BITS, default 128, AES key length; legal values 128, 192, 256.
REQ-002 SHALL derive local constants NK = KEY_BITS/32, NR = NK+6, NW = 4*(NR+1): 44, 52 or 60 words.
REQ-003 SHALL have pi_clk  input  1  clock, all state updated on rising edge.
REQ-004 SHALL have pi_rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have pi_key  input  256  cipher key, MSB-aligned; bits [255:256-KEY_BITS] used, rest ignored.
REQ-006 SHALL have pi_start  input  1  request expansion of pi_key.
REQ-007 SHALL have pi_rd_round  input  4  round-key index to read, 0..NR.
REQ-008 SHALL have po_busy  output  1  expansion in progress.
REQ-009 SHALL have po_done  output  1  single-cycle pulse, schedule complete.
REQ-010 SHALL have po_key_valid  output  1  stored schedule matches last accepted key.
REQ-011 SHALL have po_round_key  output  128  registered round key for pi_rd_round.

Function
REQ-012 SHALL implement states IDLE and RUN; no other states.
REQ-013 In IDLE, pi_start=1 at an edge SHALL capture words w[0..NK-1] from pi_key, clear word counter i to NK, clear rcon to 0x01, enter RUN, set po_busy=1, set po_key_valid=0.
REQ-014 In RUN, each edge SHALL compute and store exactly one word w[i] = w[i-NK] XOR temp, then increment i.
REQ-015 temp SHALL be SubWord(RotWord(w[i-1])) XOR {rcon,24'h0} when i mod NK = 0; SubWord(w[i-1]) when NK=8 and i mod 8 = 4; otherwise w[i-1].
REQ-016 rcon SHALL advance by GF(2^8) xtime (shift left, XOR 0x1B on carry) after each use; sequence 01,02,04,08,10,20,40,80,1B,36.
REQ-017 The edge storing w[NW-1] SHALL return to IDLE, clear po_busy, set po_key_valid=1, and assert po_done for exactly the following cycle.
REQ-018 Latency SHALL be NW-NK edges from the start-accept edge to the last-word edge: 40 (128), 46 (192), 52 (256).
REQ-019 pi_start while in RUN SHALL be ignored; running expansion unaffected.
REQ-020 pi_start on the cycle po_done is high SHALL be accepted normally and restart expansion.
REQ-021 Round-key storage SHALL hold all NW words; SubWord uses four combinational S-box byte lookups.
REQ-022 po_round_key SHALL update every edge to {w[4r],w[4r+1],w[4r+2],w[4r+3]} with r = pi_rd_round; one-cycle read latency.
REQ-023 pi_rd_round > NR SHALL yield po_round_key = 0.
REQ-024 Reads during RUN SHALL return current storage contents; only po_key_valid qualifies them.

Reset
REQ-025 pi_rst=1 SHALL force IDLE, i=0, rcon=0x01, po_busy=0, po_done=0, po_key_valid=0, po_round_key=0, all stored words=0.
REQ-026 Reset asserted mid-RUN SHALL abort expansion; no po_done pulse after release.
REQ-027 First pi_start SHALL be accepted on the first edge after pi_rst deasserts.

Configuration
REQ-028 Macro KEY_SCHEDULE_ZEROIZE_EN SHALL, when defined, add input pi_zeroize (1 bit) to the port list.
REQ-029 With KEY_SCHEDULE_ZEROIZE_EN defined, pi_zeroize=1 at an edge SHALL clear all stored words, po_round_key, po_key_valid, po_busy, po_done and return to IDLE, with priority over pi_start.
REQ-030 Without KEY_SCHEDULE_ZEROIZE_EN, the port SHALL not exist and stored words SHALL clear only by pi_rst.

Verification
REQ-031 KEY_BITS=128, key 2b7e151628aed2a6abf7158809cf4f3c, start -> po_done 40 edges later; round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
REQ-032 KEY_BITS=192, key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b -> done after 46 edges; round 12 = e98ba06f448c773c8ecc720401002202.
REQ-033 KEY_BITS=256, key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4 -> done after 52 edges; round 14 = fe4890d1e6188d0b046df344706c631e.
REQ-034 Second pi_start at edge 10 of RUN -> ignored; same done timing and round keys as REQ-031.
REQ-035 pi_rst pulsed at edge 20 of RUN -> all outputs 0, no po_done; new start then completes in 40 edges.
REQ-036 pi_rd_round=11 with KEY_BITS=128 -> po_round_key=0; with KEY_SCHEDULE_ZEROIZE_EN, pi_zeroize after done -> po_key_valid=0, round 0 reads 0.

Source files
------------

// File: rtl/key_schedule_gen.sv
// AES key expansion engine (FIPS-197 schedule for 128/192/256-bit keys).
// Generates one expanded word per clock into an on-chip word store and
// serves any round key from that store with one cycle of read latency.
// Optional feature: define KEY_SCHEDULE_ZEROIZE_EN to add pi_zeroize, which
// wipes the stored schedule and all outputs and returns the engine to IDLE.
module key_schedule_gen #(
    parameter int KEY_BITS = 128
) (
    input  logic         pi_clk,
    input  logic         pi_rst,
    input  logic [255:0] pi_key,
    input  logic         pi_start,
    input  logic [3:0]   pi_rd_round,
`ifdef KEY_SCHEDULE_ZEROIZE_EN
    input  logic         pi_zeroize,
`endif
    output logic         po_busy,
    output logic         po_done,
    output logic         po_key_valid,
    output logic [127:0] po_round_key
);

    localparam int NK = KEY_BITS / 32;
    localparam int NR = NK + 6;
    localparam int NW = 4 * (NR + 1);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t       stateQ;
    logic [5:0]   idxQ;
    logic [2:0]   phaseQ;
    logic [7:0]   rconQ;
    logic [7:0]   rconD;
    logic         busyQ;
    logic         doneQ;
    logic         validQ;
    logic [127:0] roundKeyQ;
    logic [127:0] roundKeyD;
    logic [31:0]  wordsQ [NW];
    logic [31:0]  wordD;
    logic [31:0]  prevWord;
    logic [31:0]  backWord;
    logic [31:0]  tempWord;
    logic         zeroize;
    logic         acceptStart;
    logic         runStep;
    logic         lastWord;
    logic         keyParityUnused;

    // Four parallel S-box byte lookups.
    function automatic logic [31:0] subWord(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

`ifdef KEY_SCHEDULE_ZEROIZE_EN
    assign zeroize = pi_zeroize;
`else
    assign zeroize = 1'b0;
`endif

    // Key bits below the active key length are deliberately ignored.
    assign keyParityUnused = ^pi_key;

    assign acceptStart = (stateQ == IDLE) && pi_start && !zeroize;
    assign runStep     = (stateQ == RUN) && !zeroize;
    assign lastWord    = (idxQ == 6'(NW - 1));
    assign rconD       = {rconQ[6:0], 1'b0} ^ (rconQ[7] ? 8'h1b : 8'h00);

    // Fetch w[i-1] and w[i-NK] by compare-select so no index ever leaves the store.
    always_comb begin
        prevWord = '0;
        backWord = '0;
        for (int k = 0; k < NW; k++) begin
            if (6'(k) == idxQ - 6'd1) begin
                prevWord = wordsQ[k];
            end
            if (6'(k) == idxQ - 6'(NK)) begin
                backWord = wordsQ[k];
            end
        end
    end

    // Word recurrence: phase tracks i mod NK so no divider is needed.
    always_comb begin
        tempWord = prevWord;
        if (phaseQ == 3'd0) begin
            tempWord = subWord({prevWord[23:0], prevWord[31:24]}) ^ {rconQ, 24'h0};
        end else if ((NK == 8) && (phaseQ == 3'd4)) begin
            tempWord = subWord(prevWord);
        end
        wordD = backWord ^ tempWord;
    end

    // Round-key read mux; indices past the last round read as zero.
    always_comb begin
        roundKeyD = '0;
        for (int r = 0; r <= NR; r++) begin
            if (pi_rd_round == 4'(r)) begin
                roundKeyD = {wordsQ[4*r], wordsQ[4*r+1], wordsQ[4*r+2], wordsQ[4*r+3]};
            end
        end
    end

    // Control FSM: accepts a key in IDLE and steps one word per clock in RUN.
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            stateQ <= IDLE;
            idxQ   <= '0;
            phaseQ <= '0;
            rconQ  <= 8'h01;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
            validQ <= 1'b0;
        end else if (zeroize) begin
            stateQ <= IDLE;
            idxQ   <= '0;
            phaseQ <= '0;
            rconQ  <= 8'h01;
            busyQ  <= 1'b0;
            doneQ  <= 1'b0;
            validQ <= 1'b0;
        end else begin
            case (stateQ)
                IDLE: begin
                    doneQ <= 1'b0;
                    if (pi_start) begin
                        stateQ <= RUN;
                        idxQ   <= 6'(NK);
                        phaseQ <= '0;
                        rconQ  <= 8'h01;
                        busyQ  <= 1'b1;
                        validQ <= 1'b0;
                    end
                end
                RUN: begin
                    idxQ   <= idxQ + 6'd1;
                    phaseQ <= (phaseQ == 3'(NK - 1)) ? 3'd0 : phaseQ + 3'd1;
                    if (phaseQ == 3'd0) begin
                        rconQ <= rconD;
                    end
                    doneQ <= lastWord;
                    if (lastWord) begin
                        stateQ <= IDLE;
                        busyQ  <= 1'b0;
                        validQ <= 1'b1;
                    end
                end
                default: begin
                    stateQ <= IDLE;
                    busyQ  <= 1'b0;
                    doneQ  <= 1'b0;
                end
            endcase
        end
    end

    // Word store: key words land on accept, then one derived word per RUN clock.
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            for (int k = 0; k < NW; k++) begin
                wordsQ[k] <= '0;
            end
        end else if (zeroize) begin
            for (int k = 0; k < NW; k++) begin
                wordsQ[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NW; k++) begin
                if (acceptStart && (k < NK)) begin
                    wordsQ[k] <= pi_key[255 - 32*k -: 32];
                end else if (runStep && (idxQ == 6'(k))) begin
                    wordsQ[k] <= wordD;
                end
            end
        end
    end

    // Registered round-key output, refreshed every clock.
    always_ff @(posedge pi_clk or posedge pi_rst) begin
        if (pi_rst) begin
            roundKeyQ <= '0;
        end else if (zeroize) begin
            roundKeyQ <= '0;
        end else begin
            roundKeyQ <= roundKeyD;
        end
    end

    assign po_busy      = busyQ;
    assign po_done      = doneQ;
    assign po_key_valid = validQ;
    assign po_round_key = roundKeyQ;

endmodule
